// File: rtl/wb_arb2.sv
// wb_arb2: two-master Wishbone arbiter (CPU m0, DMA/video m1) in front of the RAM slave, with bus-timeout error.
// Build option: define ARB_ROUND_ROBIN_EN for round-robin tie-break; the default build gives ties to m0.
module wb_arb2 #(
    parameter int AW         = 13,
    parameter int TMO_CYCLES = 64
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_n_i,
    input  logic          m0_cyc_i,
    input  logic          m0_stb_i,
    input  logic          m0_we_i,
    input  logic [1:0]    m0_sel_i,
    input  logic [AW-1:0] m0_adr_i,
    input  logic [15:0]   m0_dat_i,
    output logic [15:0]   m0_dat_o,
    output logic          m0_ack_o,
    output logic          m0_err_o,
    input  logic          m1_cyc_i,
    input  logic          m1_stb_i,
    input  logic          m1_we_i,
    input  logic [1:0]    m1_sel_i,
    input  logic [AW-1:0] m1_adr_i,
    input  logic [15:0]   m1_dat_i,
    output logic [15:0]   m1_dat_o,
    output logic          m1_ack_o,
    output logic          m1_err_o,
    output logic          s_cyc_o,
    output logic          s_stb_o,
    output logic          s_we_o,
    output logic [1:0]    s_sel_o,
    output logic [AW-1:0] s_adr_o,
    output logic [15:0]   s_dat_o,
    input  logic [15:0]   s_dat_i,
    input  logic          s_ack_i,
    output logic [1:0]    dbg_state,
    output logic          dbg_last_gnt,
    output logic [7:0]    dbg_tmo_cnt
);

    // Handshake: a master owns the slave from the cycle after its grant until it drops cyc;
    // a transfer completes in any cycle where s_cyc_o & s_stb_o & s_ack_i are all high.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    localparam logic [7:0] TMO_LAST = 8'(TMO_CYCLES - 1);

    state_t     state;
    logic       last_gnt;
    logic [7:0] tmo_cnt;
    logic       err0_q, err1_q;
    logic       stall, tmo_hit, tie_to_m1;

`ifdef ARB_ROUND_ROBIN_EN
    assign tie_to_m1 = ~last_gnt;
`else
    assign tie_to_m1 = 1'b0;
`endif

    // The strobe is suppressed during the error cycle so the slave never sees the stalled request twice.
    always_comb begin
        s_cyc_o = 1'b0;
        s_stb_o = 1'b0;
        s_we_o  = 1'b0;
        s_sel_o = 2'b00;
        s_adr_o = '0;
        s_dat_o = 16'h0000;
        case (state)
            GNT0: begin
                s_cyc_o = m0_cyc_i;
                s_stb_o = m0_stb_i & ~(err0_q | err1_q);
                s_we_o  = m0_we_i;
                s_sel_o = m0_sel_i;
                s_adr_o = m0_adr_i;
                s_dat_o = m0_dat_i;
            end
            GNT1: begin
                s_cyc_o = m1_cyc_i;
                s_stb_o = m1_stb_i & ~(err0_q | err1_q);
                s_we_o  = m1_we_i;
                s_sel_o = m1_sel_i;
                s_adr_o = m1_adr_i;
                s_dat_o = m1_dat_i;
            end
            default: ;
        endcase
    end

    assign stall   = s_cyc_o & s_stb_o & ~s_ack_i;
    assign tmo_hit = stall & (tmo_cnt == TMO_LAST);

    assign m0_ack_o = s_ack_i & (state == GNT0);
    assign m1_ack_o = s_ack_i & (state == GNT1);
    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;
    assign m0_err_o = err0_q;
    assign m1_err_o = err1_q;

    assign dbg_state    = state;
    assign dbg_last_gnt = last_gnt;
    assign dbg_tmo_cnt  = tmo_cnt;

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state    <= IDLE;
            last_gnt <= 1'b1;
            tmo_cnt  <= 8'd0;
            err0_q   <= 1'b0;
            err1_q   <= 1'b0;
        end else begin
            err0_q <= tmo_hit & (state == GNT0);
            err1_q <= tmo_hit & (state == GNT1);
            if (state == IDLE || !stall || tmo_hit)
                tmo_cnt <= 8'd0;
            else
                tmo_cnt <= tmo_cnt + 8'd1;

            // Grants always pass through IDLE, so a dropping master cannot be re-granted back-to-back.
            case (state)
                IDLE: begin
                    if (m0_cyc_i && m1_cyc_i) begin
                        if (tie_to_m1) begin
                            state    <= GNT1;
                            last_gnt <= 1'b1;
                        end else begin
                            state    <= GNT0;
                            last_gnt <= 1'b0;
                        end
                    end else if (m0_cyc_i) begin
                        state    <= GNT0;
                        last_gnt <= 1'b0;
                    end else if (m1_cyc_i) begin
                        state    <= GNT1;
                        last_gnt <= 1'b1;
                    end
                end
                GNT0:    if (!m0_cyc_i) state <= IDLE;
                GNT1:    if (!m1_cyc_i) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_arb2.sv
// tb_wb_arb2: bench for wb_arb2 with a two-stage RAM slave model and a reference memory / grant-order model.
`timescale 1ns/1ps
module tb_wb_arb2;
  localparam int AW  = 13;
  localparam int TMO = 8;
`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  typedef struct {
    logic          we;
    logic [AW-1:0] adr;
    logic [15:0]   dat;
    logic [1:0]    sel;
  } txn_t;

  // clock / reset
  logic wb_clk_i = 1'b0;
  logic wb_rst_n_i = 1'b0;
  always #5 wb_clk_i = ~wb_clk_i;

  logic          m0_cyc_i, m0_stb_i, m0_we_i, m1_cyc_i, m1_stb_i, m1_we_i;
  logic [1:0]    m0_sel_i, m1_sel_i, s_sel_o, dbg_state;
  logic [AW-1:0] m0_adr_i, m1_adr_i, s_adr_o;
  logic [15:0]   m0_dat_i, m1_dat_i, m0_dat_o, m1_dat_o, s_dat_o, s_dat_i;
  logic          m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
  logic          s_cyc_o, s_stb_o, s_we_o, s_ack_i, dbg_last_gnt;
  logic [7:0]    dbg_tmo_cnt;

  wb_arb2 #(.AW(AW), .TMO_CYCLES(TMO)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_n_i(wb_rst_n_i),
    .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i), .m0_sel_i(m0_sel_i),
    .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o),
    .m0_err_o(m0_err_o),
    .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i), .m1_sel_i(m1_sel_i),
    .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o),
    .m1_err_o(m1_err_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i),
    .dbg_state(dbg_state), .dbg_last_gnt(dbg_last_gnt), .dbg_tmo_cnt(dbg_tmo_cnt)
  );

  // RAM slave model: writes ack in the strobe cycle, reads ack after two register stages.
  logic [15:0] ram [0:63];
  logic        p1, p2, mute;
  logic [5:0]  rd_adr;
  logic        rd_req;
  assign rd_req  = s_cyc_o & s_stb_o & ~s_we_o & ~p1 & ~p2;
  assign s_ack_i = ~mute & ((s_cyc_o & s_stb_o & s_we_o) | p2);
  assign s_dat_i = ram[rd_adr];

  always @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      p1 <= 1'b0;
      p2 <= 1'b0;
      rd_adr <= 6'd0;
      for (int i = 0; i < 64; i++) ram[i] <= 16'h0000;
      ram[6'h20] <= 16'hBEEF;
    end else begin
      p1 <= ~mute & rd_req;
      p2 <= ~mute & p1;
      if (rd_req) rd_adr <= s_adr_o[5:0];
      if (~mute & s_cyc_o & s_stb_o & s_we_o) begin
        if (s_sel_o[0]) ram[s_adr_o[5:0]][7:0]  <= s_dat_o[7:0];
        if (s_sel_o[1]) ram[s_adr_o[5:0]][15:8] <= s_dat_o[15:8];
      end
    end
  end

  // scoreboard / reference model
  int errors = 0;
  int checks = 0;
  logic [15:0] ref_mem [int];
  bit   model_last;
  txn_t q0[$], q1[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] ref_rd(input logic [AW-1:0] a);
    return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : 16'h0000;
  endfunction

  task automatic ref_wr(input logic [AW-1:0] a, input logic [15:0] d, input logic [1:0] sel);
    logic [15:0] v;
    v = ref_rd(a);
    if (sel[0]) v[7:0]  = d[7:0];
    if (sel[1]) v[15:8] = d[15:8];
    ref_mem[int'(a)] = v;
  endtask

  task automatic ref_reset();
    ref_mem.delete();
    ref_mem[32'h20] = 16'hBEEF;
    model_last = 1'b1;
  endtask

  // driver tasks
  task automatic drive(input int m, input txn_t t);
    if (m == 0) begin
      m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_we_i = t.we;
      m0_adr_i = t.adr; m0_dat_i = t.dat; m0_sel_i = t.sel;
    end else begin
      m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_we_i = t.we;
      m1_adr_i = t.adr; m1_dat_i = t.dat; m1_sel_i = t.sel;
    end
  endtask

  task automatic release_m(input int m);
    if (m == 0) begin m0_cyc_i = 1'b0; m0_stb_i = 1'b0; m0_we_i = 1'b0; end
    else        begin m1_cyc_i = 1'b0; m1_stb_i = 1'b0; m1_we_i = 1'b0; end
  endtask

  function automatic txn_t mk(input logic we, input int adr, input int dat, input int sel);
    txn_t t;
    t.we = we; t.adr = AW'(adr); t.dat = 16'(dat); t.sel = 2'(sel);
    return t;
  endfunction

  // Both masters start together; each drops cyc for one cycle after its ack, then issues its next transfer.
  task automatic run_bus(input string tag);
    int   c, prev_ack, got_m, exp_m, got_n, total;
    bit   drop0, drop1, rearm0, rearm1;
    txn_t t;
    total = q0.size() + q1.size();
    prev_ack = -2;
    got_n = 0; c = 0;
    drop0 = 0; drop1 = 0; rearm0 = 0; rearm1 = 0;
    @(posedge wb_clk_i); #1;
    if (q0.size() > 0) drive(0, q0[0]);
    if (q1.size() > 0) drive(1, q1[0]);
    while (got_n < total && c < 400) begin
      @(negedge wb_clk_i);
      if (m0_ack_o | m1_ack_o) begin
        chk({tag, "_ack_excl"}, {31'd0, m0_ack_o & m1_ack_o}, 32'd0);
        got_m = m1_ack_o ? 1 : 0;
        if (q0.size() > 0 && q1.size() > 0) exp_m = (RR && !model_last) ? 1 : 0;
        else exp_m = (q0.size() > 0) ? 0 : 1;
        chk({tag, "_order"}, got_m, exp_m);
        t = (got_m == 1) ? q1[0] : q0[0];
        chk({tag, "_latency"}, c, prev_ack + 2 + (t.we ? 1 : 3));
        if (!t.we) chk({tag, "_rdata"}, {16'd0, (got_m == 1) ? m1_dat_o : m0_dat_o}, {16'd0, ref_rd(t.adr)});
        else ref_wr(t.adr, t.dat, t.sel);
        model_last = got_m[0];
        if (got_m == 1) begin void'(q1.pop_front()); drop1 = 1; end
        else            begin void'(q0.pop_front()); drop0 = 1; end
        prev_ack = c;
        got_n++;
      end
      @(posedge wb_clk_i); #1;
      c++;
      if (drop0) begin release_m(0); drop0 = 0; rearm0 = 1; end
      else if (rearm0) begin rearm0 = 0; if (q0.size() > 0) drive(0, q0[0]); end
      if (drop1) begin release_m(1); drop1 = 0; rearm1 = 1; end
      else if (rearm1) begin rearm1 = 0; if (q1.size() > 0) drive(1, q1[0]); end
    end
    chk({tag, "_completed"}, got_n, total);
    release_m(0); release_m(1);
    q0.delete(); q1.delete();
    repeat (3) @(posedge wb_clk_i);
    #1;
  endtask

  initial begin
    int n0, n1;
    m0_cyc_i = 0; m0_stb_i = 0; m0_we_i = 0; m0_sel_i = 0; m0_adr_i = '0; m0_dat_i = 0;
    m1_cyc_i = 0; m1_stb_i = 0; m1_we_i = 0; m1_sel_i = 0; m1_adr_i = '0; m1_dat_i = 0;
    mute = 1'b0;
    ref_reset();
    repeat (3) @(posedge wb_clk_i);
    #2 wb_rst_n_i = 1'b1;

    // reset state
    @(negedge wb_clk_i);
    chk("rst_state", {30'd0, dbg_state}, 32'd0);
    chk("rst_last_gnt", {31'd0, dbg_last_gnt}, 32'd1);
    chk("rst_s_cyc", {31'd0, s_cyc_o}, 32'd0);
    chk("rst_acks_errs", {28'd0, m0_ack_o, m1_ack_o, m0_err_o, m1_err_o}, 32'd0);

    // single write from m0 with field checks
    @(posedge wb_clk_i); #1;
    drive(0, mk(1'b1, 'h010, 'h1234, 3));
    @(negedge wb_clk_i);
    chk("wr_c0_stb", {31'd0, s_stb_o}, 32'd0);
    @(negedge wb_clk_i);
    chk("wr_c1_stb", {31'd0, s_stb_o}, 32'd1);
    chk("wr_c1_fields", {s_we_o, s_sel_o, s_adr_o, s_dat_o}, {1'b1, 2'b11, 13'h010, 16'h1234});
    chk("wr_c1_acks", {30'd0, m0_ack_o, m1_ack_o}, 32'd2);
    ref_wr(13'h010, 16'h1234, 2'b11);
    model_last = 1'b0;
    @(posedge wb_clk_i); #1;
    release_m(0);
    repeat (2) @(posedge wb_clk_i);
    #1;

    // single read from m1 of the preloaded word, then read back m0's write
    q1.push_back(mk(1'b0, 'h020, 0, 3));
    q1.push_back(mk(1'b0, 'h010, 0, 3));
    run_bus("rd_m1");

    // sustained tie: four transfers each
    for (int i = 0; i < 4; i++) begin
      q0.push_back(mk(1'b1, 'h030 + i, 'hA000 + i, 3));
      q1.push_back(mk(1'b1, 'h038 + i, 'hB000 + i, 3));
    end
    run_bus("tie");

    // timeout: slave never acks
    mute = 1'b1;
    @(posedge wb_clk_i); #1;
    drive(0, mk(1'b0, 'h005, 0, 3));
    for (int c = 0; c <= 10; c++) begin
      @(negedge wb_clk_i);
      if (c == 1) chk("tmo_c1_cnt", {24'd0, dbg_tmo_cnt}, 32'd0);
      if (c == 8) begin
        chk("tmo_c8_err", {31'd0, m0_err_o}, 32'd0);
        chk("tmo_c8_cnt", {24'd0, dbg_tmo_cnt}, TMO - 1);
      end
      if (c == 9) begin
        chk("tmo_c9_errs", {30'd0, m0_err_o, m1_err_o}, 32'd2);
        chk("tmo_c9_stb", {31'd0, s_stb_o}, 32'd0);
        chk("tmo_c9_cnt", {24'd0, dbg_tmo_cnt}, 32'd0);
        chk("tmo_c9_state", {30'd0, dbg_state}, 32'd1);
      end
      if (c == 10) begin
        chk("tmo_c10_err", {31'd0, m0_err_o}, 32'd0);
        chk("tmo_c10_stb", {31'd0, s_stb_o}, 32'd1);
        chk("tmo_c10_cnt", {24'd0, dbg_tmo_cnt}, 32'd0);
      end
      @(posedge wb_clk_i); #1;
    end
    release_m(0);
    mute = 1'b0;
    model_last = 1'b0;
    repeat (3) @(posedge wb_clk_i);
    #1;

    // asynchronous reset in the middle of an m1 read
    drive(1, mk(1'b0, 'h020, 0, 3));
    repeat (2) @(posedge wb_clk_i);
    @(negedge wb_clk_i);
    chk("arst_pre_state", {30'd0, dbg_state}, 32'd2);
    #1 wb_rst_n_i = 1'b0;
    #1;
    chk("arst_s_cyc", {31'd0, s_cyc_o}, 32'd0);
    chk("arst_s_stb_adr", {s_stb_o, s_adr_o}, 32'd0);
    chk("arst_acks_errs", {28'd0, m0_ack_o, m1_ack_o, m0_err_o, m1_err_o}, 32'd0);
    chk("arst_state", {30'd0, dbg_state}, 32'd0);
    release_m(1);
    ref_reset();
    @(posedge wb_clk_i);
    #3 wb_rst_n_i = 1'b1;
    q0.push_back(mk(1'b1, 'h011, 'h5A5A, 3));
    q1.push_back(mk(1'b1, 'h012, 'hA5A5, 3));
    run_bus("post_rst_tie");

    // randomized rounds
    for (int r = 0; r < 8; r++) begin
      n0 = $urandom_range(0, 3);
      n1 = $urandom_range(0, 3);
      for (int i = 0; i < n0; i++)
        q0.push_back(mk(1'($urandom_range(0, 1)), $urandom_range(0, 15), $urandom, $urandom_range(1, 3)));
      for (int i = 0; i < n1; i++)
        q1.push_back(mk(1'($urandom_range(0, 1)), $urandom_range(0, 15), $urandom, $urandom_range(1, 3)));
      run_bus("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
